// File: rtl/audio_i2s_tx.sv
// Philips I2S serializer for the mixer's signed 16-bit stereo output.
// BCK and LRCK are divided down from clk; one coherent L/R pair is captured per frame.
module audio_i2s_tx #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mute,
  input  logic [15:0] audio_l,
  input  logic [15:0] audio_r,
  output logic        i2s_bck,
  output logic        i2s_lrck,
  output logic        i2s_data,
  output logic        sample_req
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [15:0]      shadow_l_reg, shadow_l_next;
  logic [15:0]      shadow_r_reg, shadow_r_next;
  logic             bck_reg, bck_next;
  logic             lrck_reg, lrck_next;
  logic             data_reg, data_next;
  logic             req_reg, req_next;

  logic             div_wrap, fall_event, capture, right_slot, payload;
  logic [BIT_W-1:0] bit_cnt_inc, slot_pos;
  logic [3:0]       bit_sel;
  logic [15:0]      ch_word;

  always_comb begin
    div_wrap     = (div_cnt_reg == DIV_LAST);
    fall_event   = div_wrap && bck_reg;
    div_cnt_next = div_wrap ? '0 : div_cnt_reg + DIV_W'(1);
    bck_next     = div_wrap ? ~bck_reg : bck_reg;

    // Everything below looks at the bit counter value that takes effect at this fall.
    bit_cnt_inc = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + BIT_W'(1);
    right_slot  = (bit_cnt_inc >= SLOT);
    slot_pos    = right_slot ? bit_cnt_inc - SLOT : bit_cnt_inc;
    capture     = fall_event && (bit_cnt_inc == '0);

    // Position 0 is the one-bit I2S delay, so freshly captured shadows are first read at position 1.
    bit_sel = 4'(5'd16 - 5'(slot_pos));
    ch_word = right_slot ? shadow_r_reg : shadow_l_reg;
    payload = (slot_pos >= BIT_W'(1) && slot_pos <= BIT_W'(16)) ? ch_word[bit_sel] : 1'b0;

    bit_cnt_next  = fall_event ? bit_cnt_inc : bit_cnt_reg;
    lrck_next     = fall_event ? right_slot : lrck_reg;
    data_next     = fall_event ? payload : data_reg;
    req_next      = capture;
    shadow_l_next = capture ? (mute ? 16'h0000 : audio_l) : shadow_l_reg;
    shadow_r_next = capture ? (mute ? 16'h0000 : audio_r) : shadow_r_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= BIT_LAST;
      shadow_l_reg <= '0;
      shadow_r_reg <= '0;
      bck_reg      <= 1'b0;
      lrck_reg     <= 1'b0;
      data_reg     <= 1'b0;
      req_reg      <= 1'b0;
    end else begin
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shadow_l_reg <= shadow_l_next;
      shadow_r_reg <= shadow_r_next;
      bck_reg      <= bck_next;
      lrck_reg     <= lrck_next;
      data_reg     <= data_next;
      req_reg      <= req_next;
    end
  end

  assign i2s_bck    = bck_reg;
  assign i2s_lrck   = lrck_reg;
  assign i2s_data   = data_reg;
  assign sample_req = req_reg;

endmodule
